max_frame_ctrl: RTL and testbench
=================================

Name: max_frame_ctrl

Overview:
Sequencing controller for the 8-bit maximum-compare datapath. It accepts a frame of FRAME_LEN unsigned samples over a valid/ready stream and drives a single registered max comparator across that frame. It then presents the frame maximum and the index of that maximum on a valid/ready result port. It sits between a sample producer and any consumer of per-frame peak values.

Parameters:
DATA_W, 8, sample and result width (unsigned).
FRAME_LEN, 4, samples per frame; legal range 1..255.
IDX_W, 3, width of the count and index; must satisfy 2**IDX_W > FRAME_LEN-1 (values up to FRAME_LEN-1 must fit).

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  begin a frame; sampled only in IDLE.
clr  in  1  synchronous abort; returns to IDLE from any state.
in_valid  in  1  in_data is valid.
in_ready  out  1  block accepts a sample this cycle.
in_data  in  DATA_W  sample value.
out_valid  out  1  out_max and out_idx are valid.
out_ready  in  1  consumer accepts the result.
out_max  out  DATA_W  frame maximum.
out_idx  out  IDX_W  index (0-based) of the first occurrence of the maximum.
busy  out  1  high in ACCUM and HOLD.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, cnt=0; out_max=0, out_idx=0, out_valid=0, in_ready=0, busy=0.
- All outputs are registered or decoded from the state register only. There are no combinational paths from inputs to outputs.
- States: IDLE, ACCUM, HOLD.
- IDLE: in_ready=0, out_valid=0, busy=0.
  - start=1 -> ACCUM next cycle, cnt<=0.
  - in_valid is ignored.
- ACCUM: in_ready=1, busy=1. An accept is in_valid & in_ready.
  - On accept with cnt==0: max_r<=in_data, idx_r<=0.
  - On accept with cnt>0: if in_data > max_r (unsigned, strict), max_r<=in_data and idx_r<=cnt. Ties keep the earlier index.
  - Each accept increments cnt.
  - An accept with cnt==FRAME_LEN-1 -> HOLD next cycle, and out_valid rises on that same edge. Latency from the last accept to out_valid is 1 cycle.
  - in_valid gaps stall the block without penalty.
  - start is ignored while in ACCUM.
- HOLD: out_valid=1, in_ready=0, busy=1. out_max and out_idx are stable.
  - out_ready=1 -> IDLE next cycle; out_valid falls.
  - start is ignored.
  - out_ready may already be high on the cycle out_valid rises; the handshake then completes in that cycle.
- out_max and out_idx keep their last values after the handshake. They change only when the next frame's first sample is accepted.
- clr=1 has priority over every other input in every state:
  - next state IDLE, cnt<=0, out_valid<=0;
  - out_max and out_idx are left unchanged;
  - a partial frame is discarded with no result.
- Reset asserted mid-frame or in HOLD: immediate return to reset values, independent of clk.
- FRAME_LEN=1: the first accept goes straight to HOLD with idx=0.
- cnt never wraps. It is cleared on start and clr and never exceeds FRAME_LEN-1.
- All-zero frame: out_max=0, out_idx=0.
- Maximum value 255 in the frame: later 255s do not move the index.

Test Plan:
- Reset, then start, then a frame of 10,20,20,5 with in_valid every cycle -> out_valid 1 cycle after the 4th accept, out_max=20, out_idx=1; busy falls one cycle after out_ready.
- Frame 30,20,40,40 with in_valid gaps of 2 cycles between samples, and out_ready held low for 3 cycles -> in_ready=0 and out_max=40, out_idx=2 are stable during HOLD; return to IDLE the cycle after out_ready=1.
- Frame 0,0,0,0 -> out_max=0, out_idx=0. Then frame 255,1,255,254 -> out_max=255, out_idx=0.
- Start, accept 50 and 60, assert clr for 1 cycle, then start a new frame 7,8,9,3 -> no out_valid for the aborted frame; result out_max=9, out_idx=2.
- Drop rst_n asynchronously mid-frame after 2 accepts -> all outputs 0 immediately. Release, start, frame 1,2,3,4 -> out_max=4, out_idx=3.
- start pulsed during ACCUM and HOLD, and in_valid driven in IDLE -> no effect on cnt, state or result. FRAME_LEN=1 build: sample 99 -> out_valid next cycle, out_max=99, out_idx=0.

Source files
------------

// File: rtl/max_frame_ctrl.sv
// Frame maximum sequencer: accepts FRAME_LEN samples over valid/ready, tracks the
// running maximum and the index of its first occurrence, then holds the result.
module max_frame_ctrl #(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 4,
  parameter int IDX_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_max,
  output logic [IDX_W-1:0]  out_idx,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t              state_r, state_n;
  logic [IDX_W-1:0]    cnt_r, cnt_n;
  logic [DATA_W-1:0]   max_r, max_n;
  logic [IDX_W-1:0]    idx_r, idx_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      max_r   <= '0;
      idx_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      max_r   <= max_n;
      idx_r   <= idx_n;
    end
  end

  // clr wins over everything but leaves the last result visible
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    max_n   = max_r;
    idx_n   = idx_r;
    if (clr) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_n = ACCUM;
            cnt_n   = '0;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            // strict compare keeps the earliest index on ties
            if (cnt_r == '0 || in_data > max_r) begin
              max_n = in_data;
              idx_n = cnt_r;
            end
            if (cnt_r == LAST_IDX) begin
              state_n = HOLD;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt_r + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == ACCUM);
  assign out_valid = (state_r == HOLD);
  assign busy      = (state_r == ACCUM) || (state_r == HOLD);
  assign out_max   = max_r;
  assign out_idx   = idx_r;

endmodule

// File: tb/tb_max_frame_ctrl.sv
// Directed bench for max_frame_ctrl: a per-cycle vector table for the main
// FRAME_LEN=4 instance, plus hand sequences for async reset and a FRAME_LEN=1 build.
module tb_max_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, clr, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid, busy;
  logic [7:0] out_max;
  logic [2:0] out_idx;

  logic       start1, clr1, in_valid1, out_ready1;
  logic [7:0] in_data1;
  logic       in_ready1, out_valid1, busy1;
  logic [7:0] out_max1;
  logic [0:0] out_idx1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  max_frame_ctrl #(.DATA_W(8), .FRAME_LEN(4), .IDX_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_max(out_max), .out_idx(out_idx), .busy(busy)
  );

  max_frame_ctrl #(.DATA_W(8), .FRAME_LEN(1), .IDX_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .clr(clr1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_max(out_max1), .out_idx(out_idx1), .busy(busy1)
  );

  typedef struct {
    logic       st, cl, iv;
    logic [7:0] d;
    logic       ordy;
    logic       ir, ov, bz;
    logic [7:0] mx;
    logic [2:0] ix;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int st, input int cl, input int iv, input int d, input int ordy,
                     input int ir, input int ov, input int bz, input int mx, input int ix);
    vec_t v;
    v.st = (st != 0); v.cl = (cl != 0); v.iv = (iv != 0);
    v.d = 8'(d); v.ordy = (ordy != 0);
    v.ir = (ir != 0); v.ov = (ov != 0); v.bz = (bz != 0);
    v.mx = 8'(mx); v.ix = 3'(ix);
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic st, input logic cl, input logic iv,
                               input logic [7:0] d, input logic ordy);
    start = st; clr = cl; in_valid = iv; in_data = d; out_ready = ordy;
  endtask

  // packed as {in_ready, out_valid, busy, max[7:0], idx[2:0]}
  task automatic checkOutput(input string name, input logic [13:0] act, input logic [13:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got ir=%b ov=%b busy=%b max=%0d idx=%0d, need ir=%b ov=%b busy=%b max=%0d idx=%0d",
               name, act[13], act[12], act[11], act[10:3], act[2:0],
               exp[13], exp[12], exp[11], exp[10:3], exp[2:0]);
    end
  endtask

  function automatic logic [13:0] dut0Outs();
    return {in_ready, out_valid, busy, out_max, out_idx};
  endfunction

  function automatic logic [13:0] dut1Outs();
    return {in_ready1, out_valid1, busy1, out_max1, 2'b00, out_idx1};
  endfunction

  task automatic stepCheck(input string name, input logic st, input logic cl, input logic iv,
                           input logic [7:0] d, input logic ordy, input logic [13:0] exp);
    applyStimulus(st, cl, iv, d, ordy);
    @(posedge clk); #1;
    checkOutput(name, dut0Outs(), exp);
  endtask

  initial begin
    // frame 10,20,20,5 back to back
    add(1,0,0,0,0,   1,0,1,0,0);
    add(0,0,1,10,0,  1,0,1,10,0);
    add(0,0,1,20,0,  1,0,1,20,1);
    add(0,0,1,20,0,  1,0,1,20,1);
    add(0,0,1,5,0,   0,1,1,20,1);
    add(0,0,0,0,1,   0,0,0,20,1);
    // frame 30,20,40,40 with 2-cycle gaps, consumer stalls 3 cycles
    add(1,0,0,0,0,   1,0,1,20,1);
    add(0,0,1,30,0,  1,0,1,30,0);
    add(0,0,0,0,0,   1,0,1,30,0);
    add(0,0,0,0,0,   1,0,1,30,0);
    add(0,0,1,20,0,  1,0,1,30,0);
    add(0,0,0,0,0,   1,0,1,30,0);
    add(0,0,0,0,0,   1,0,1,30,0);
    add(0,0,1,40,0,  1,0,1,40,2);
    add(0,0,0,0,0,   1,0,1,40,2);
    add(0,0,0,0,0,   1,0,1,40,2);
    add(0,0,1,40,0,  0,1,1,40,2);
    add(0,0,0,0,0,   0,1,1,40,2);
    add(1,0,1,99,0,  0,1,1,40,2);
    add(0,0,0,0,0,   0,1,1,40,2);
    add(0,0,0,0,1,   0,0,0,40,2);
    add(0,0,1,77,0,  0,0,0,40,2);
    // all-zero frame, consumer ready before the result appears
    add(1,0,0,0,0,   1,0,1,40,2);
    add(0,0,1,0,0,   1,0,1,0,0);
    add(0,0,1,0,0,   1,0,1,0,0);
    add(0,0,1,0,0,   1,0,1,0,0);
    add(0,0,1,0,1,   0,1,1,0,0);
    add(0,0,0,0,1,   0,0,0,0,0);
    // 255 first, later 255 must not move the index
    add(1,0,0,0,0,   1,0,1,0,0);
    add(0,0,1,255,0, 1,0,1,255,0);
    add(0,0,1,1,0,   1,0,1,255,0);
    add(0,0,1,255,0, 1,0,1,255,0);
    add(0,0,1,254,0, 0,1,1,255,0);
    add(0,0,0,0,1,   0,0,0,255,0);
    // abort after 2 accepts, then 7,8,9,3 with a stray start mid-frame
    add(1,0,0,0,0,   1,0,1,255,0);
    add(0,0,1,50,0,  1,0,1,50,0);
    add(0,0,1,60,0,  1,0,1,60,1);
    add(0,1,1,70,0,  0,0,0,60,1);
    add(0,0,0,0,0,   0,0,0,60,1);
    add(1,0,0,0,0,   1,0,1,60,1);
    add(0,0,1,7,0,   1,0,1,7,0);
    add(1,0,1,8,0,   1,0,1,8,1);
    add(0,0,1,9,0,   1,0,1,9,2);
    add(0,0,1,3,0,   0,1,1,9,2);
    add(0,1,0,0,1,   0,0,0,9,2);
    add(1,1,0,0,0,   0,0,0,9,2);

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    start1 = 1'b0; clr1 = 1'b0; in_valid1 = 1'b0; in_data1 = 8'd0; out_ready1 = 1'b0;
    #2;
    checkOutput("reset_state", dut0Outs(), 14'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'd33, 1'b0);
    @(posedge clk); #1;
    checkOutput("reset_holds", dut0Outs(), 14'd0);
    checkOutput("reset_state_len1", dut1Outs(), 14'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].st, vecs[i].cl, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d", i), dut0Outs(),
                  {vecs[i].ir, vecs[i].ov, vecs[i].bz, vecs[i].mx, vecs[i].ix});
    end

    // asynchronous reset mid-frame after two accepts
    stepCheck("ar_start", 1'b1, 1'b0, 1'b0, 8'd0,  1'b0, {3'b101, 8'd9,  3'd2});
    stepCheck("ar_acc0",  1'b0, 1'b0, 1'b1, 8'd11, 1'b0, {3'b101, 8'd11, 3'd0});
    stepCheck("ar_acc1",  1'b0, 1'b0, 1'b1, 8'd12, 1'b0, {3'b101, 8'd12, 3'd1});
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_async_clear", dut0Outs(), 14'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("ar_idle_after", dut0Outs(), 14'd0);
    stepCheck("ar_restart", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, {3'b101, 8'd0, 3'd0});
    stepCheck("ar_s1", 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, {3'b101, 8'd1, 3'd0});
    stepCheck("ar_s2", 1'b0, 1'b0, 1'b1, 8'd2, 1'b0, {3'b101, 8'd2, 3'd1});
    stepCheck("ar_s3", 1'b0, 1'b0, 1'b1, 8'd3, 1'b0, {3'b101, 8'd3, 3'd2});
    stepCheck("ar_s4", 1'b0, 1'b0, 1'b1, 8'd4, 1'b0, {3'b011, 8'd4, 3'd3});
    stepCheck("ar_done", 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, {3'b000, 8'd4, 3'd3});

    // single-sample frames
    start1 = 1'b1;
    @(posedge clk); #1;
    checkOutput("len1_start", dut1Outs(), {3'b101, 8'd0, 3'd0});
    start1 = 1'b0; in_valid1 = 1'b1; in_data1 = 8'd99;
    @(posedge clk); #1;
    checkOutput("len1_hold", dut1Outs(), {3'b011, 8'd99, 3'd0});
    in_valid1 = 1'b0; out_ready1 = 1'b1;
    @(posedge clk); #1;
    checkOutput("len1_idle", dut1Outs(), {3'b000, 8'd99, 3'd0});
    out_ready1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
